// File: rtl/sram_bridge_pkg.sv
// Shared constants for the AVR-to-SRAM bridge:
// FSM state encoding and access type.
package sram_bridge_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_t;

endpackage

// File: rtl/sram_bridge_addr_sreg_counter.sv
// SRAM address register: serial load, manual and
// auto increment with natural wrap.
module addr_sreg_counter
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              shift_en,
    input  logic              si,
    input  logic              count,
    input  logic              auto_inc,
    output logic [ADDR_W-1:0] addr
);

    // Shift beats a coincident manual count; auto
    // increment comes from DONE, so it ignores hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (!hold && shift_en) begin
            addr <= {addr[ADDR_W-2:0], si};
        end else if (!hold && count) begin
            addr <= addr + ADDR_W'(1);
        end else if (auto_inc) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/sram_bridge.sv
// AVR-to-SRAM bus bridge: serial address load,
// strobed read/write cycles, SNES pass-through.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              avr_clk,
    input  logic              avr_reset_n,
    input  logic              avr_sreg_en_n,
    input  logic              avr_si,
    input  logic              avr_counter_n,
    input  logic              avr_auto_inc,
    input  logic              avr_oe_n,
    input  logic              avr_we_n,
    input  logic              avr_snes_mode,
    input  logic [DATA_W-1:0] avr_data_in,
    output logic [DATA_W-1:0] avr_data_out,
    output logic              avr_ready,
    output logic              busy,
    input  logic [ADDR_W-1:0] snes_addr,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic [DATA_W-1:0] sram_data_out,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int CNT_W =
        (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(WAIT_CYCLES - 1);

    logic [2:0]        state;
    acc_t              acc;
    logic [DATA_W-1:0] wdata;
    logic [CNT_W-1:0]  cnt;
    logic              snes_q;
    logic              oe_q, oe_qq;
    logic              we_q, we_qq;
    logic              cn_q, cn_qq;
    logic              rd_fall, wr_fall, cn_fall;
    logic              idle, snes_on;
    logic [ADDR_W-1:0] addr;

    assign rd_fall = oe_qq & ~oe_q;
    assign wr_fall = we_qq & ~we_q;
    assign cn_fall = cn_qq & ~cn_q;
    assign idle    = (state == S_IDLE);
    assign snes_on = snes_q & idle;

    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            oe_q  <= 1'b1;
            oe_qq <= 1'b1;
            we_q  <= 1'b1;
            we_qq <= 1'b1;
            cn_q  <= 1'b1;
            cn_qq <= 1'b1;
        end else begin
            oe_q  <= avr_oe_n;
            oe_qq <= oe_q;
            we_q  <= avr_we_n;
            we_qq <= we_q;
            cn_q  <= avr_counter_n;
            cn_qq <= cn_q;
        end
    end

    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            state        <= S_IDLE;
            acc          <= ACC_READ;
            wdata        <= '0;
            cnt          <= '0;
            snes_q       <= 1'b0;
            avr_data_out <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    snes_q <= avr_snes_mode;
                    if (!snes_q && wr_fall) begin
                        state <= S_SETUP;
                        acc   <= ACC_WRITE;
                        wdata <= avr_data_in;
                    end else if (!snes_q && rd_fall) begin
                        state <= S_SETUP;
                        acc   <= ACC_READ;
                    end
                end
                S_SETUP: begin
                    state <= S_STROBE;
                    cnt   <= '0;
                end
                S_STROBE: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (acc == ACC_WRITE) begin
                        state <= S_HOLD;
                    end else begin
                        state        <= S_DONE;
                        avr_data_out <= sram_data_in;
                    end
                end
                S_HOLD:  state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_data_oe = 1'b0;
        unique case (1'b1)
            snes_on: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            (state == S_SETUP),
            (state == S_HOLD): begin
                sram_ce_n    = 1'b0;
                sram_data_oe = (acc == ACC_WRITE);
            end
            (state == S_STROBE): begin
                sram_ce_n    = 1'b0;
                sram_data_oe = (acc == ACC_WRITE);
                sram_oe_n    = (acc == ACC_WRITE);
                sram_we_n    = (acc == ACC_READ);
            end
            default: ;
        endcase
    end

    assign sram_data_out = wdata;
    assign sram_addr     = snes_on ? snes_addr : addr;
    assign avr_ready     = (state == S_DONE);
    assign busy          = ~idle;

    addr_sreg_counter #(.ADDR_W(ADDR_W)) u_addr (
        .clk      (avr_clk),
        .rst_n    (avr_reset_n),
        .hold     (~idle | snes_q),
        .shift_en (~avr_sreg_en_n),
        .si       (avr_si),
        .count    (cn_fall),
        .auto_inc ((state == S_DONE) & avr_auto_inc),
        .addr     (addr)
    );

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Parametrised AVR-to-SRAM bus bridge; next generation of the fixed 8-bit/21-bit sreg + bus FSM pair in `system`. Loads the SRAM address serially from the AVR, supports manual and auto-increment addressing, and runs read/write cycles with a configurable strobe width. In SNES mode it hands the SRAM to the SNES address bus. Sits between the AVR pins and the SRAM pins inside the CPLD top level.

## Interface
- `ADDR_W`, 21, SRAM address width (≥ 2).
- `DATA_W`, 8, data width.
- `WAIT_CYCLES`, 2, cycles the SRAM OE/WE strobe is held low (≥ 1).

- `avr_clk`  in  1  system clock, all logic on rising edge.
- `avr_reset_n`  in  1  asynchronous, active-low reset.
- `avr_sreg_en_n`  in  1  low: shift `avr_si` into the address register.
- `avr_si`  in  1  serial address bit, MSB first.
- `avr_counter_n`  in  1  falling edge: address + 1.
- `avr_auto_inc`  in  1  high: address + 1 after every completed access.
- `avr_oe_n` / `avr_we_n`  in  1  falling edge requests read / write.
- `avr_snes_mode`  in  1  high: SRAM owned by SNES.
- `avr_data_in`  in  DATA_W  write data.
- `avr_data_out`  out  DATA_W  registered read data.
- `avr_ready`  out  1  one-cycle pulse on access completion.
- `busy`  out  1  high from request accept until the cycle after DONE.
- `snes_addr`  in  ADDR_W  SNES address.
- `sram_addr`  out  ADDR_W; `sram_data_in`  in  DATA_W; `sram_data_out`  out  DATA_W; `sram_data_oe`  out  1; `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1.

## Operation
- Reset values: address 0, state IDLE, `sram_ce_n`/`sram_oe_n`/`sram_we_n` = 1, `sram_data_oe` = 0, `avr_data_out` = 0, `avr_ready` = 0, `busy` = 0, mode = AVR. Reset mid-access deasserts all strobes at once (asynchronous).
- Edge detection: `avr_oe_n`, `avr_we_n`, `avr_counter_n` registered; falling edge = previous 1, current 0.
- Address register (IDLE only): `avr_sreg_en_n` = 0 → `addr <= {addr[ADDR_W-2:0], avr_si}` per clock. Counter edge → `addr + 1`, wraps `2^ADDR_W-1 → 0`. Shift and counter edge in same cycle: shift wins, increment dropped. Both ignored outside IDLE.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
  - IDLE: read edge → SETUP(read); write edge → SETUP(write), latch `avr_data_in`. Both edges same cycle: write wins, read dropped.
  - SETUP (1 cycle): `sram_ce_n` = 0; write drives `sram_data_oe` = 1.
  - STROBE (WAIT_CYCLES cycles): read `sram_oe_n` = 0; write `sram_we_n` = 0. Read data captured into `avr_data_out` on last STROBE edge.
  - HOLD (write only, 1 cycle): `sram_we_n` = 1, data and CE still driven.
  - DONE (1 cycle): CE/OE/WE high, `sram_data_oe` = 0, `avr_ready` = 1; if `avr_auto_inc`, address + 1 (wrap as above). → IDLE.
- Edges arriving outside IDLE are lost; AVR must poll `busy`.
- SNES mode: `avr_snes_mode` sampled in IDLE only; asserted mid-access, access completes first. In SNES mode: `sram_addr` = `snes_addr`, `sram_ce_n` = 0, `sram_oe_n` = 0, `sram_we_n` = 1, `sram_data_oe` = 0; AVR requests, shifts and counter edges ignored. Otherwise `sram_addr` = address register.

## Timing
- Pin edge sampled at edge k (registered), detected at k+1 → SETUP during cycle k+1.
- Read: STROBE cycles k+2 … k+1+W, DONE k+2+W; total W+3 cycles edge-to-ready.
- Write: STROBE k+2 … k+1+W, HOLD k+2+W, DONE k+3+W.
- `busy` high SETUP through DONE; next request accepted one cycle after DONE.
- Shift/count take effect the cycle after sampling; `sram_addr` stable from SETUP to DONE.

## Structure
- `sram_bridge_pkg`: state encoding localparams, access-type enum constants.
- Sub-module `addr_sreg_counter` (parametrised by ADDR_W): shift, manual and auto increment, wrap, shift-over-count priority, external `hold` input asserted outside IDLE.

## Test plan
- Shift 21 bits of 0x04CCF MSB-first with `avr_sreg_en_n` = 0 → `sram_addr` = 0x04CCF.
- Read, W=2, SRAM drives 0xAA → `sram_oe_n` low 2 cycles, `avr_ready` 5 cycles after edge, `avr_data_out` = 0xAA.
- Write 0xEE with `avr_auto_inc` = 1 at 0x04CCF → `sram_we_n` low 2 cycles, data driven SETUP–HOLD, address 0x04CD0 after DONE.
- Counter edge at 0x1FFFFF → 0x000000; counter edge during shift → ignored.
- Read and write edges same cycle → only write performed; read edge during `busy` → no second access.
- `avr_snes_mode` raised mid-write → write completes, then `sram_addr` follows `snes_addr`; `avr_reset_n` low mid-access → CE/OE/WE = 1 immediately, address 0.
